// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, tag owners
// and a width helper for occupancy counters.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   // Bits needed to hold a count in the range 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Small in-order FIFO of read owners; one entry per outstanding read so
// each memory response can be steered back to the port that issued it.
module arb_tag_fifo
   import mem_arb_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = cnt_width(DEPTH)
) (
   input  logic          clock,
   input  logic          clear_n,
   input  logic          push,
   input  owner_t        din,
   input  logic          pop,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output owner_t        head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   owner_t        slots [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && !full;
   assign head    = slots[rd_ptr];

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset; validity is tracked by the count.
   always_ff @(posedge clock) begin
      if (do_push) slots[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one request/grant memory port between the
// instruction-fetch and data ports, with in-order read response routing.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MAX_RD = 2
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err
);

   localparam int CW = cnt_width(MAX_RD);

   arb_state_t    state;
   arb_state_t    state_nxt;
   owner_t        rr_ptr;
   owner_t        sel;
   logic          sel_req;
   logic          sel_read;
   logic          blocked;
   logic          grant;
   logic          push;
   logic          err_q;
   logic [CW-1:0] tag_count;
   logic          tag_full;
   logic          tag_empty;
   owner_t        tag_head;

   // A stalled request keeps ownership of the memory port until granted.
   always_comb begin
      sel = rr_ptr;
      unique case (state)
         HOLD_I:  sel = OWN_I;
         HOLD_D:  sel = OWN_D;
         default: if (i_req != d_req) sel = i_req ? OWN_I : OWN_D;
      endcase
   end

   assign sel_req  = (sel == OWN_I) ? i_req : d_req;
   assign sel_read = (sel == OWN_I) || !d_we;
   assign blocked  = (tag_count == CW'(MAX_RD)) && sel_read;
   assign grant    = sel_req && !blocked && mem_gnt;
   assign push     = grant && sel_read && !tag_full;

   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_gnt     = 1'b0;
      d_gnt     = 1'b0;
      if (reset_n) begin
         mem_req   = sel_req && !blocked;
         mem_we    = sel_req && !blocked && (sel == OWN_D) && d_we;
         mem_addr  = (sel == OWN_I) ? i_addr : d_addr;
         mem_wdata = d_wdata;
         i_gnt     = grant && (sel == OWN_I);
         d_gnt     = grant && (sel == OWN_D);
      end
      unique case (state)
         IDLE: begin
            if (sel_req && !blocked && !mem_gnt)
               state_nxt = (sel == OWN_I) ? HOLD_I : HOLD_D;
         end
         default: begin
            if (mem_gnt) state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         rr_ptr <= OWN_D;
         err_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant) rr_ptr <= (sel == OWN_I) ? OWN_D : OWN_I;
         if (mem_rvalid && tag_empty) err_q <= 1'b1;
      end
   end

   arb_tag_fifo #(.DEPTH(MAX_RD)) u_tags (
      .clock   (clock),
      .clear_n (reset_n),
      .push    (push),
      .din     (sel),
      .pop     (mem_rvalid),
      .count   (tag_count),
      .full    (tag_full),
      .empty   (tag_empty),
      .head    (tag_head)
   );

   // A response with no matching tag is dropped rather than misrouted.
   assign i_rvalid = reset_n && mem_rvalid && !tag_empty && (tag_head == OWN_I);
   assign d_rvalid = reset_n && mem_rvalid && !tag_empty && (tag_head == OWN_D);
   assign i_rdata  = reset_n ? mem_rdata : '0;
   assign d_rdata  = reset_n ? mem_rdata : '0;
   assign err      = reset_n && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; read responses are checked against a
// scoreboard of expected owners filled as reads are granted.
module tb_mem_arbiter;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } rsp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        i_req, d_req, d_we, mem_gnt, mem_rvalid;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

   rsp_t sb[$];
   rsp_t cur;
   logic rr_d;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_RD(2)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_gnt      (i_gnt),
      .i_rvalid   (i_rvalid),
      .i_rdata    (i_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .err        (err)
   );

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      i_req      = 1'b0;
      d_req      = 1'b0;
      d_we       = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
   endtask

   // Memory returns the next expected response from the scoreboard.
   task automatic apply_stimulus_rsp();
      if (sb.size() == 0) begin
         errors++;
         $error("[TB] FAIL sb_underflow: observed empty expected entry");
         cur = '0;
      end else begin
         cur = sb.pop_front();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = cur.data;
   endtask

   task automatic check_output_rsp(input string tag);
      check_bit({tag, "_i_rvalid"}, i_rvalid, !cur.is_d);
      check_bit({tag, "_d_rvalid"}, d_rvalid, cur.is_d);
      check_word({tag, "_rdata"}, cur.is_d ? d_rdata : i_rdata, cur.data);
   endtask

   task automatic check_output_zero(input string tag);
      check_bit({tag, "_mem_req"}, mem_req, 1'b0);
      check_bit({tag, "_mem_we"}, mem_we, 1'b0);
      check_word({tag, "_mem_addr"}, mem_addr, 32'h0);
      check_word({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      check_bit({tag, "_i_gnt"}, i_gnt, 1'b0);
      check_bit({tag, "_d_gnt"}, d_gnt, 1'b0);
      check_bit({tag, "_i_rvalid"}, i_rvalid, 1'b0);
      check_bit({tag, "_d_rvalid"}, d_rvalid, 1'b0);
      check_word({tag, "_i_rdata"}, i_rdata, 32'h0);
      check_word({tag, "_d_rdata"}, d_rdata, 32'h0);
      check_bit({tag, "_err"}, err, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      i_req      = 1'b1;
      d_req      = 1'b1;
      i_addr     = 32'h1000;
      d_addr     = 32'h2000;
      d_wdata    = 32'h0000CAFE;
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h77;
      #2;
      check_output_zero("por");
      sample();
      check_output_zero("por_edge");
      next_cycle();
      reset_n = 1'b1;
      idle_inputs();
      sample();
      check_bit("post_por_err", err, 1'b0);
      check_bit("post_por_mem_req", mem_req, 1'b0);

      // Both ports stream reads into a one-cycle memory.
      next_cycle();
      rr_d = 1'b1;
      for (int k = 0; k < 5; k++) begin
         i_req      = (k < 4);
         d_req      = (k < 4);
         d_we       = 1'b0;
         i_addr     = 32'h1000;
         d_addr     = 32'h2000;
         mem_gnt    = 1'b1;
         mem_rvalid = 1'b0;
         if (k > 0) apply_stimulus_rsp();
         sample();
         if (k > 0) check_output_rsp($sformatf("rr_rsp%0d", k));
         if (k < 4) begin
            check_bit($sformatf("rr_d_gnt%0d", k), d_gnt, rr_d);
            check_bit($sformatf("rr_i_gnt%0d", k), i_gnt, !rr_d);
            check_word($sformatf("rr_addr%0d", k), mem_addr, rr_d ? 32'h2000 : 32'h1000);
            sb.push_back('{is_d: rr_d, data: 32'hA0 + k});
            rr_d = !rr_d;
         end else begin
            check_bit("rr_quiet_mem_req", mem_req, 1'b0);
         end
         next_cycle();
      end

      // Posted write stalled for three cycles while fetch starts requesting.
      idle_inputs();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h100;
      d_wdata = 32'hDEADBEEF;
      sample();
      check_bit("wr_mem_req", mem_req, 1'b1);
      check_bit("wr_mem_we", mem_we, 1'b1);
      check_word("wr_addr0", mem_addr, 32'h100);
      check_bit("wr_d_gnt0", d_gnt, 1'b0);
      for (int c = 1; c < 3; c++) begin
         next_cycle();
         i_req  = 1'b1;
         i_addr = 32'h1000;
         sample();
         check_word($sformatf("wr_addr%0d", c), mem_addr, 32'h100);
         check_word($sformatf("wr_wdata%0d", c), mem_wdata, 32'hDEADBEEF);
         check_bit($sformatf("wr_i_gnt%0d", c), i_gnt, 1'b0);
         check_bit($sformatf("wr_d_gnt%0d", c), d_gnt, 1'b0);
      end
      next_cycle();
      mem_gnt = 1'b1;
      sample();
      check_bit("wr_d_gnt3", d_gnt, 1'b1);
      check_bit("wr_i_gnt3", i_gnt, 1'b0);
      check_word("wr_addr3", mem_addr, 32'h100);
      next_cycle();
      d_req = 1'b0;
      d_we  = 1'b0;
      sample();
      check_bit("wr_then_i_gnt", i_gnt, 1'b1);
      check_word("wr_then_i_addr", mem_addr, 32'h1000);
      check_bit("wr_then_we", mem_we, 1'b0);
      sb.push_back('{is_d: 1'b0, data: 32'h66});
      next_cycle();
      i_req   = 1'b0;
      mem_gnt = 1'b0;
      apply_stimulus_rsp();
      sample();
      check_output_rsp("wr_no_tag");

      // Fill the tag FIFO and confirm a third read is held off.
      next_cycle();
      idle_inputs();
      mem_gnt = 1'b1;
      d_req   = 1'b1;
      d_addr  = 32'h300;
      sample();
      check_bit("blk_d_gnt0", d_gnt, 1'b1);
      sb.push_back('{is_d: 1'b1, data: 32'h33});
      next_cycle();
      d_req  = 1'b0;
      i_req  = 1'b1;
      i_addr = 32'h400;
      sample();
      check_bit("blk_i_gnt0", i_gnt, 1'b1);
      sb.push_back('{is_d: 1'b0, data: 32'h44});
      next_cycle();
      i_addr = 32'h500;
      sample();
      check_bit("blk_third_mem_req", mem_req, 1'b0);
      check_bit("blk_third_i_gnt", i_gnt, 1'b0);
      next_cycle();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h200;
      d_wdata = 32'h12345678;
      sample();
      check_bit("blk_wr_d_gnt", d_gnt, 1'b1);
      check_bit("blk_wr_i_gnt", i_gnt, 1'b0);
      check_bit("blk_wr_we", mem_we, 1'b1);
      check_word("blk_wr_addr", mem_addr, 32'h200);
      next_cycle();
      d_req = 1'b0;
      d_we  = 1'b0;
      apply_stimulus_rsp();
      sample();
      check_output_rsp("blk_rsp0");
      check_bit("blk_no_bypass_mem_req", mem_req, 1'b0);
      check_bit("blk_no_bypass_i_gnt", i_gnt, 1'b0);
      next_cycle();
      mem_rvalid = 1'b0;
      sample();
      check_bit("blk_unblock_i_gnt", i_gnt, 1'b1);
      check_word("blk_unblock_addr", mem_addr, 32'h500);
      sb.push_back('{is_d: 1'b0, data: 32'h55});
      next_cycle();
      i_req = 1'b0;
      apply_stimulus_rsp();
      sample();
      check_output_rsp("blk_rsp1");
      next_cycle();
      apply_stimulus_rsp();
      sample();
      check_output_rsp("blk_rsp2");

      // Grant and response in the same cycle leave occupancy unchanged.
      next_cycle();
      idle_inputs();
      mem_gnt = 1'b1;
      i_req   = 1'b1;
      i_addr  = 32'h600;
      sample();
      check_bit("pp_i_gnt", i_gnt, 1'b1);
      sb.push_back('{is_d: 1'b0, data: 32'h11});
      next_cycle();
      i_req  = 1'b0;
      d_req  = 1'b1;
      d_addr = 32'h700;
      apply_stimulus_rsp();
      sample();
      check_output_rsp("pp_rsp0");
      check_bit("pp_d_gnt", d_gnt, 1'b1);
      sb.push_back('{is_d: 1'b1, data: 32'h22});
      next_cycle();
      d_req = 1'b0;
      apply_stimulus_rsp();
      sample();
      check_output_rsp("pp_rsp1");

      // Stray response with nothing outstanding.
      next_cycle();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h99;
      sample();
      check_bit("stray_i_rvalid", i_rvalid, 1'b0);
      check_bit("stray_d_rvalid", d_rvalid, 1'b0);
      check_bit("stray_err_pre", err, 1'b0);
      next_cycle();
      mem_rvalid = 1'b0;
      sample();
      check_bit("stray_err_set", err, 1'b1);
      next_cycle();
      sample();
      check_bit("stray_err_sticky", err, 1'b1);

      // Reset while a read is outstanding and a fetch is stalled.
      next_cycle();
      idle_inputs();
      mem_gnt = 1'b1;
      d_req   = 1'b1;
      d_addr  = 32'h800;
      sample();
      check_bit("rst_pre_d_gnt", d_gnt, 1'b1);
      next_cycle();
      d_req   = 1'b0;
      i_req   = 1'b1;
      i_addr  = 32'h900;
      mem_gnt = 1'b0;
      sample();
      check_bit("rst_hold_mem_req", mem_req, 1'b1);
      check_bit("rst_hold_i_gnt", i_gnt, 1'b0);
      next_cycle();
      d_req  = 1'b1;
      d_addr = 32'hA00;
      sample();
      check_word("rst_hold_frozen_addr", mem_addr, 32'h900);
      check_bit("rst_hold_d_gnt", d_gnt, 1'b0);
      next_cycle();
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBB;
      d_wdata    = 32'hFF;
      reset_n    = 1'b0;
      #1;
      check_output_zero("rst_async");
      next_cycle();
      check_output_zero("rst_edge");
      sb.delete();
      next_cycle();
      reset_n = 1'b1;
      idle_inputs();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCC;
      sample();
      check_bit("rst_empty_d_rvalid", d_rvalid, 1'b0);
      check_bit("rst_empty_i_rvalid", i_rvalid, 1'b0);
      check_bit("rst_err_cleared", err, 1'b0);
      next_cycle();
      mem_rvalid = 1'b0;
      i_req      = 1'b1;
      d_req      = 1'b1;
      d_we       = 1'b0;
      mem_gnt    = 1'b1;
      sample();
      check_bit("rst_ptr_d_gnt", d_gnt, 1'b1);
      check_bit("rst_ptr_i_gnt", i_gnt, 1'b0);
      check_bit("rst_stray_err", err, 1'b1);

      next_cycle();
      idle_inputs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
